shift_sched: RTL and testbench

Arbitration and sequencing controller for the 32-bit, 4-stage pipelined barrel shifter. It accepts shift/rotate requests from two requesters over valid/ready handshakes and grants them round-robin. Granted operations issue into the free-running shifter, which has no stall or enable. Each result is tracked with a requester ID through a valid/tag pipeline matched to the shifter latency, captured into a result FIFO, and returned with backpressure. A credit scheme guarantees the FIFO never overflows.

---
 rtl/shift_sched.sv | 180 ++++++++++++++++++
 tb/tb_shift_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sched.sv
// Round-robin issue controller for a 4-stage barrel shifter: tag pipeline, result FIFO, credit flow control.
// Optional statistics counters are built only when SHIFT_SCHED_STATS_EN is defined.
module shift_sched #(
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_amt,
    input  logic        req0_rot,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_amt,
    input  logic        req1_rot,
    output logic [31:0] sh_a,
    output logic [4:0]  sh_b,
    output logic        sh_r,
    input  logic [31:0] sh_s,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic [15:0] stat_issue0,
    output logic [15:0] stat_issue1,
    output logic [15:0] stat_stall
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  amt;
        logic        rot;
    } op_t;

    logic [CW-1:0] out_cnt;
    logic          last;
    logic          credit;
    logic          pop;
    logic          push;
    logic          issue;
    logic          grant_id;
    op_t           op0;
    op_t           op1;
    op_t           op_sel;

    // ---------------- arbitration and issue ----------------
    assign op0 = '{data: req0_data, amt: req0_amt, rot: req0_rot};
    assign op1 = '{data: req1_data, amt: req1_amt, rot: req1_rot};

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        credit     = (out_cnt < DEPTH_C) || pop;
        grant_id   = (req0_valid && req1_valid) ? ~last : req1_valid;
        req0_ready = credit && req0_valid && !grant_id;
        req1_ready = credit && req1_valid && grant_id;
        issue      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        op_sel     = '0;
        if (issue) begin
            op_sel = grant_id ? op1 : op0;
        end
    end

    assign sh_a = op_sel.data;
    assign sh_b = op_sel.amt;
    assign sh_r = op_sel.rot;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            last    <= 1'b1;
            out_cnt <= '0;
        end else begin
            if (issue) begin
                last <= grant_id;
            end
            case ({issue, pop})
                2'b10:   out_cnt <= out_cnt + CW'(1);
                2'b01:   out_cnt <= out_cnt - CW'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    // ---------------- tag pipeline matched to the shifter ----------------
    logic [LATENCY-1:0] tag_v;
    logic [LATENCY-1:0] tag_id;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= issue;
            tag_id[0] <= grant_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign push = tag_v[LATENCY-1];

    // ---------------- result FIFO ----------------
    logic [31:0]   mem_data [FIFO_DEPTH];
    logic          mem_id   [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;

    // NOTE: storage is not reset; occupancy is, so stale entries are never presented.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_data[wr_ptr] <= sh_s;
            mem_id[wr_ptr]   <= tag_id[LATENCY-1];
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign rsp_valid = (fifo_cnt != '0);
    assign pop       = rsp_valid && rsp_ready;
    // Outputs read as zero while empty so the post-reset value is defined.
    assign rsp_data  = rsp_valid ? mem_data[rd_ptr] : 32'd0;
    assign rsp_id    = rsp_valid ? mem_id[rd_ptr]   : 1'b0;

    // ---------------- statistics ----------------
`ifdef SHIFT_SCHED_STATS_EN
    logic stall_any;
    assign stall_any = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            stat_issue0 <= '0;
            stat_issue1 <= '0;
            stat_stall  <= '0;
        end else begin
            if (req0_valid && req0_ready && stat_issue0 != 16'hFFFF) begin
                stat_issue0 <= stat_issue0 + 16'd1;
            end
            if (req1_valid && req1_ready && stat_issue1 != 16'hFFFF) begin
                stat_issue1 <= stat_issue1 + 16'd1;
            end
            if (stall_any && stat_stall != 16'hFFFF) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`else
    assign stat_issue0 = 16'd0;
    assign stat_issue1 = 16'd0;
    assign stat_stall  = 16'd0;
`endif

endmodule

// File: tb/tb_shift_sched.sv
// Randomised and directed bench for shift_sched with a transaction-queue reference model and a shifter model.
// Expected statistics follow SHIFT_SCHED_STATS_EN.
module tb_shift_sched;

    localparam int LATENCY = 4;
    localparam int DEPTH   = 8;
`ifdef SHIFT_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 0, req1_valid = 0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_data = 0, req1_data = 0;
    logic [4:0]  req0_amt = 0, req1_amt = 0;
    logic        req0_rot = 0, req1_rot = 0;
    logic [31:0] sh_a;
    logic [4:0]  sh_b;
    logic        sh_r;
    logic [31:0] sh_s;
    logic        rsp_valid;
    logic        rsp_ready = 0;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic [15:0] stat_issue0, stat_issue1, stat_stall;

    shift_sched #(.LATENCY(LATENCY), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_rot(req0_rot),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_rot(req1_rot),
        .sh_a(sh_a), .sh_b(sh_b), .sh_r(sh_r), .sh_s(sh_s),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .stat_issue0(stat_issue0), .stat_issue1(stat_issue1), .stat_stall(stat_stall)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] shf(logic [31:0] a, logic [4:0] b, logic r);
        logic [63:0] w;
        w = {a, a} << b;
        return r ? w[63:32] : (a << b);
    endfunction

    // Free-running shifter model without reset: result appears LATENCY edges after capture.
    logic [31:0] pipe [LATENCY];
    always @(posedge clock) begin
        pipe[0] <= shf(sh_a, sh_b, sh_r);
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign sh_s = pipe[LATENCY-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: every issued op in order, with the cycle it becomes visible at the FIFO head.
    typedef struct {
        logic        id;
        logic [31:0] data;
        int          rc;
    } ent_t;
    ent_t q[$];
    logic m_last;
    int   m_i0, m_i1, m_st;
    int   cyc;

    logic        s_r0, s_r1, s_rv, s_rid;
    logic [31:0] s_rd;
    logic [15:0] s_st0, s_st1, s_stl;
    int          s_cyc;

    task automatic tick();
        logic head, pop, credit, g, e0, e1;
        logic [31:0] ea;
        logic [4:0]  eb;
        logic        er;
        @(negedge clock);
        head   = (q.size() > 0) && (q[0].rc <= cyc);
        pop    = head && rsp_ready;
        credit = (q.size() < DEPTH) || pop;
        g      = (req0_valid && req1_valid) ? !m_last : req1_valid;
        e0     = credit && req0_valid && !g;
        e1     = credit && req1_valid && g;
        check("req0_ready", req0_ready, e0);
        check("req1_ready", req1_ready, e1);
        check("rsp_valid", rsp_valid, head);
        if (head) begin
            check("rsp_data", rsp_data, q[0].data);
            check("rsp_id", rsp_id, q[0].id);
        end
        ea = 0; eb = 0; er = 0;
        if (e0) begin ea = req0_data; eb = req0_amt; er = req0_rot; end
        if (e1) begin ea = req1_data; eb = req1_amt; er = req1_rot; end
        check("sh_a", sh_a, ea);
        check("sh_b", sh_b, eb);
        check("sh_r", sh_r, er);
        check("stat_issue0", stat_issue0, STATS ? m_i0 : 0);
        check("stat_issue1", stat_issue1, STATS ? m_i1 : 0);
        check("stat_stall", stat_stall, STATS ? m_st : 0);
        s_r0 = req0_ready; s_r1 = req1_ready; s_rv = rsp_valid; s_rid = rsp_id; s_rd = rsp_data;
        s_st0 = stat_issue0; s_st1 = stat_issue1; s_stl = stat_stall; s_cyc = cyc;
        @(posedge clock);
        if (pop) void'(q.pop_front());
        if (e0 || e1) begin
            q.push_back('{id: g, data: shf(ea, eb, er), rc: cyc + LATENCY + 1});
            m_last = g;
        end
        if (e0 && m_i0 < 16'hFFFF) m_i0++;
        if (e1 && m_i1 < 16'hFFFF) m_i1++;
        if (((req0_valid && !e0) || (req1_valid && !e1)) && m_st < 16'hFFFF) m_st++;
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_data = 0; req1_data = 0; req0_amt = 0; req1_amt = 0; req0_rot = 0; req1_rot = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        rsp_ready = 0;
        q.delete();
        m_last = 1'b1;
        m_i0 = 0; m_i1 = 0; m_st = 0;
        @(negedge clock);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_sh", {sh_a, sh_b, sh_r}, 0);
        check("rst_stats", {stat_issue0, stat_issue1, stat_stall}, 0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, found;
        #1;
        do_reset();

        // Single op: issue in cycle 2, response expected in cycle 7.
        tick(); tick();
        req0_valid = 1; req0_data = 32'h12345678; req0_amt = 5'd16; req0_rot = 1;
        tick();
        check("single_issue", s_r0, 1);
        idle_inputs();
        rsp_ready = 1;
        found = -1;
        for (int i = 0; i < 20 && found < 0; i++) begin
            tick();
            if (s_rv) begin
                found = s_cyc;
                check("single_data", s_rd, 32'h56781234);
                check("single_id", s_rid, 0);
            end
        end
        check("single_latency", found, 7);

        // Both requesters streaming: alternating grants, one response per cycle.
        do_reset();
        rsp_ready = 1;
        req0_valid = 1; req0_data = 32'hDEADBEEF; req0_amt = 0;  req0_rot = 0;
        req1_valid = 1; req1_data = 32'h0000FFFF; req1_amt = 16; req1_rot = 1;
        repeat (6) tick();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_rv) cnt++;
            check("alt_data", s_rd, (s_rid ? 32'hFFFF0000 : 32'hDEADBEEF));
        end
        check("throughput", cnt, 10);

        // Backpressure: eight credits, then stalled until a pop.
        do_reset();
        req1_valid = 1; req1_data = 32'hA5A5_0001; req1_amt = 3;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (s_r1) cnt++; end
        check("bp_issues", cnt, 8);
        rsp_ready = 1;
        tick();
        check("bp_pop_issue", s_r1, 1);
        rsp_ready = 0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (s_r1) cnt++; end
        check("bp_after", cnt, 0);

        // Reset with three ops in flight and two queued.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1; req0_data = $urandom; req0_amt = 5'($urandom); req0_rot = 1'($urandom);
            tick();
        end
        idle_inputs();
        tick();
        do_reset();
        rsp_ready = 1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (s_rv) cnt++; end
        check("reset_discard", cnt, 0);

        // Statistics: 5 req0 issues, 3 req1 issues to exhaust credit, then 3 blocked cycles.
        do_reset();
        req0_valid = 1; req0_data = 32'h1;
        repeat (5) tick();
        idle_inputs();
        req1_valid = 1; req1_data = 32'h2;
        repeat (3) tick();
        idle_inputs();
        req0_valid = 1;
        repeat (3) tick();
        idle_inputs();
        tick();
        check("stat_issue0_final", s_st0, STATS ? 5 : 0);
        check("stat_issue1_final", s_st1, STATS ? 3 : 0);
        check("stat_stall_final", s_stl, STATS ? 3 : 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req0_valid = ($urandom_range(99) < 60);
            req1_valid = ($urandom_range(99) < 60);
            req0_data = $urandom; req1_data = $urandom;
            req0_amt = 5'($urandom); req1_amt = 5'($urandom);
            req0_rot = 1'($urandom); req1_rot = 1'($urandom);
            rsp_ready = ($urandom_range(99) < 70);
            tick();
        end
        idle_inputs();
        rsp_ready = 1;
        repeat (20) tick();
        check("drain_empty", s_rv, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
